// File: rtl/ifm_window_buf.sv
// ifm_window_buf: KxK sliding-window generator for a raster-order IFM stream.
//   Takes one signed pixel per beat, row-major over an IMG_W x IMG_H frame.
//   Keeps (K-1) line buffers and emits one KxK window per beat over valid/ready.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clear           synchronous restart of frame state (counters, out_valid)
//   in_valid/ready  pixel handshake; in_data is a DW-bit signed pixel
//   out_valid/ready window handshake
//   out_win         elem(r,c) at [(r*K+c)*DW +: DW]; r=0 oldest row, c=K-1 newest col
//   out_row/col     image coordinates of the window's bottom-right pixel
//   frame_done      1-cycle pulse after the last pixel of a frame is accepted

// One line buffer: a plain shift register that advances only on accepted beats,
// so q is d delayed by exactly DEPTH accepts. Contents are never reset.
module ifm_line_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DEPTH-1:0][DW-1:0] sr;

  always_ff @(posedge clk)
    if (en) sr <= {sr[DEPTH-2:0], d};

  assign q = sr[DEPTH-1];
endmodule

module ifm_window_buf #(
  parameter int DW    = 8,
  parameter int K     = 3,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [K*K*DW-1:0]          out_win,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       frame_done
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic          accept, emit, last_col, last_pix;

  // tap[K-1] is the live pixel; tap[j] is the same column (K-1-j) rows earlier
  logic [K-1:0][DW-1:0]         tap;
  logic [K-1:0][K-1:0][DW-1:0]  win, win_nxt;

  // A new window may only enter once the current one is taken (or being taken).
  assign in_ready = ~clear & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign last_col = (col_cnt == CW'(IMG_W-1));
  assign last_pix = last_col & (row_cnt == RW'(IMG_H-1));
  // Windows that would straddle a row wrap or predate K-1 full rows are skipped.
  assign emit     = (row_cnt >= RW'(K-1)) & (col_cnt >= CW'(K-1));

  assign tap[K-1] = in_data;

  for (genvar j = 0; j < K-1; j++) begin : g_lb
    ifm_line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb (
      .clk (clk),
      .en  (accept),
      .d   (tap[j+1]),
      .q   (tap[j])
    );
  end

  // Every row shifts left by one column; the newest column comes from the taps.
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      if (c < K-1) begin : g_sh
        assign win_nxt[r][c] = win[r][c+1];
      end else begin : g_new
        assign win_nxt[r][c] = tap[r];
      end
    end
  end

  // Working window; its contents across a row wrap are never emitted.
  always_ff @(posedge clk)
    if (accept) win <= win_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      out_valid  <= 1'b0;
      out_win    <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      // Drop any pending window; next accepted pixel is (0,0).
      row_cnt    <= '0;
      col_cnt    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept & last_pix;
      if (accept) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_pix ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      // A fresh window overrides the handshake clear so back-to-back windows flow.
      if (accept & emit) begin
        out_valid <= 1'b1;
        out_win   <= win_nxt;
        out_row   <= row_cnt;
        out_col   <= col_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
